// File: rtl/pattern_driver_7458.sv
// pattern_driver_7458
// Registered 10-bit stimulus source for a downstream chip_7458 dual AND-OR
// gate. Acts as a universal shift/load register in IDLE and walks all 1024
// input combinations during a sweep, holding each one HOLD_CYCLES cycles.
// Optional compile-time feature: define PATTERN_DRIVER_CHECK_EN to compile in
// the golden model and mismatch checker for the returned p1y/p2y outputs.
module pattern_driver_7458 #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        ser_r,
  input  logic        ser_l,
  input  logic [9:0]  d,
  input  logic        sweep_start,
  input  logic        p1y_in,
  input  logic        p2y_in,
  output logic [9:0]  q,
  output logic        sweep_busy,
  output logic        sweep_done,
  output logic        err_flag,
  output logic [10:0] err_count,
  output logic [9:0]  first_err_pat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [9:0] PAT_LAST  = 10'h3FF;

  state_t      state_r;
  logic [9:0]  q_r;
  logic [7:0]  hold_cnt_r;
  logic        busy_r;
  logic        done_r;
  logic        err_flag_r;
  logic [10:0] err_count_r;
  logic [9:0]  first_err_r;
  logic        mismatch_s;

  // Expected p1y of a healthy 7458 for inputs p1a..p1f = v[0..5].
  function automatic logic golden_p1(input logic [9:0] v);
    return (v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5]);
  endfunction

  // Expected p2y of a healthy 7458 for inputs p2a..p2d = v[6..9].
  function automatic logic golden_p2(input logic [9:0] v);
    return (v[6] & v[7]) | (v[8] & v[9]);
  endfunction

`ifdef PATTERN_DRIVER_CHECK_EN
  // Compare the returned chip outputs with the golden model for the current q.
  always_comb begin
    mismatch_s = 1'b0;
    if ({p1y_in, p2y_in} != {golden_p1(q_r), golden_p2(q_r)}) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end
`else
  // Checker not built: the returned chip outputs are deliberately unused.
  logic unused_chip_s;
  always_comb begin
    unused_chip_s = p1y_in ^ p2y_in;
    mismatch_s    = 1'b0;
  end
`endif

  // Sweep FSM, shift/load register, hold counter and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      q_r         <= 10'h000;
      hold_cnt_r  <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_flag_r  <= 1'b0;
      err_count_r <= 11'd0;
      first_err_r <= 10'h000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (sweep_start) begin
            q_r         <= 10'h000;
            hold_cnt_r  <= 8'd0;
            busy_r      <= 1'b1;
            err_flag_r  <= 1'b0;
            err_count_r <= 11'd0;
            first_err_r <= 10'h000;
            state_r     <= ST_RUN;
          end else begin
            case (mode)
              2'b00:   q_r <= q_r;
              2'b01:   q_r <= {ser_r, q_r[9:1]};
              2'b10:   q_r <= {q_r[8:0], ser_l};
              2'b11:   q_r <= d;
              default: q_r <= q_r;
            endcase
          end
        end
        ST_RUN: begin
          if (hold_cnt_r == HOLD_LAST) begin
            // Terminal hold cycle: the chip has settled, sample its outputs.
            if (mismatch_s) begin
              err_flag_r  <= 1'b1;
              err_count_r <= err_count_r + 11'd1;
              if (!err_flag_r) begin
                first_err_r <= q_r;
              end
            end
            if (q_r != PAT_LAST) begin
              q_r        <= q_r + 10'd1;
              hold_cnt_r <= 8'd0;
            end else begin
              // Last pattern done; q stays at 3FF rather than wrapping.
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign q             = q_r;
  assign sweep_busy    = busy_r;
  assign sweep_done    = done_r;
  assign err_flag      = err_flag_r;
  assign err_count     = err_count_r;
  assign first_err_pat = first_err_r;

endmodule

// File: tb/tb_pattern_driver_7458.sv
// Bench for pattern_driver_7458: one instance with HOLD_CYCLES=1 checked every
// cycle against a behavioural model, one with HOLD_CYCLES=3 and a stuck-at-0
// p1y return checked against hand-computed sweep results.
module tb_pattern_driver_7458;

`ifdef PATTERN_DRIVER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // instance A: HOLD_CYCLES = 1
  logic        rst_a = 1'b0;
  logic [1:0]  mode_a = 2'b00;
  logic        ser_r_a = 1'b0, ser_l_a = 1'b0, start_a = 1'b0;
  logic [9:0]  d_a = 10'h000;
  logic        p1y_a, p2y_a;
  logic [9:0]  q_a, fe_a;
  logic        busy_a, done_a, ef_a;
  logic [10:0] ec_a;
  bit          fault2 = 1'b0;

  // instance B: HOLD_CYCLES = 3
  logic        rst_b = 1'b0;
  logic [1:0]  mode_b = 2'b00;
  logic        ser_r_b = 1'b0, ser_l_b = 1'b0, start_b = 1'b0;
  logic [9:0]  d_b = 10'h000;
  logic        p1y_b, p2y_b;
  logic [9:0]  q_b, fe_b;
  logic        busy_b, done_b, ef_b;
  logic [10:0] ec_b;
  bit          b_fin = 1'b0;

  function automatic logic chip_y1(input logic [9:0] v);
    return (&v[2:0]) | (&v[5:3]);
  endfunction
  function automatic logic chip_y2(input logic [9:0] v);
    return (&v[7:6]) | (&v[9:8]);
  endfunction

  // downstream chip models (instance B has p1y stuck at 0)
  assign p1y_a = chip_y1(q_a);
  assign p2y_a = fault2 ? 1'b1 : chip_y2(q_a);
  assign p1y_b = 1'b0;
  assign p2y_b = chip_y2(q_b);

  pattern_driver_7458 #(.HOLD_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .mode(mode_a), .ser_r(ser_r_a), .ser_l(ser_l_a),
    .d(d_a), .sweep_start(start_a), .p1y_in(p1y_a), .p2y_in(p2y_a),
    .q(q_a), .sweep_busy(busy_a), .sweep_done(done_a), .err_flag(ef_a),
    .err_count(ec_a), .first_err_pat(fe_a)
  );

  pattern_driver_7458 #(.HOLD_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_b), .mode(mode_b), .ser_r(ser_r_b), .ser_l(ser_l_b),
    .d(d_b), .sweep_start(start_b), .p1y_in(p1y_b), .p2y_in(p2y_b),
    .q(q_b), .sweep_busy(busy_b), .sweep_done(done_b), .err_flag(ef_b),
    .err_count(ec_b), .first_err_pat(fe_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of instance A ----------------
  logic [9:0]  m_q, m_fe;
  logic        m_busy, m_done, m_ef;
  logic [10:0] m_ec;
  int          sweep_pos;    // pattern index being held, -1 when no sweep
  bit          done_cycle;
  logic        m_ret2;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      m_q = 10'h000; m_fe = 10'h000; m_busy = 1'b0; m_done = 1'b0;
      m_ef = 1'b0; m_ec = 11'd0; sweep_pos = -1; done_cycle = 1'b0;
    end else if (sweep_pos >= 0) begin
      m_ret2 = fault2 ? 1'b1 : chip_y2(m_q);
      if (CHK && (m_ret2 != chip_y2(m_q))) begin
        if (!m_ef) m_fe = m_q;
        m_ef = 1'b1;
        m_ec = m_ec + 11'd1;
      end
      if (sweep_pos == 1023) begin
        m_busy = 1'b0; m_done = 1'b1; sweep_pos = -1; done_cycle = 1'b1;
      end else begin
        sweep_pos = sweep_pos + 1;
        m_q = 10'(sweep_pos);
      end
    end else if (done_cycle) begin
      m_done = 1'b0; done_cycle = 1'b0;
    end else if (start_a) begin
      m_q = 10'h000; sweep_pos = 0; m_busy = 1'b1;
      m_ef = 1'b0; m_ec = 11'd0; m_fe = 10'h000;
    end else begin
      case (mode_a)
        2'b01:   m_q = {ser_r_a, m_q[9:1]};
        2'b10:   m_q = {m_q[8:0], ser_l_a};
        2'b11:   m_q = d_a;
        default: m_q = m_q;
      endcase
    end
  end

  // every-cycle comparison of instance A against the model
  always @(posedge clk) begin
    #1;
    check("q",             q_a,    m_q);
    check("sweep_busy",    busy_a, m_busy);
    check("sweep_done",    done_a, m_done);
    check("err_flag",      ef_a,   m_ef);
    check("err_count",     ec_a,   m_ec);
    check("first_err_pat", fe_a,   m_fe);
  end

  task automatic sweep_a(input bit scramble, output int busy_n, output int done_n);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 1100; i++) begin
      if (busy_a) busy_n++;
      if (done_a) done_n++;
      if (busy_a && scramble) begin
        mode_a  = 2'($urandom_range(0, 3));
        d_a     = 10'($urandom);
        ser_r_a = 1'($urandom);
        ser_l_a = 1'($urandom);
        start_a = ($urandom_range(0, 7) == 0);
      end else begin
        start_a = 1'b0;
        mode_a  = 2'b00;
      end
      @(negedge clk);
    end
  endtask

  // instance A stimulus and literal checks
  initial begin
    int bn, dn;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    check("rst_q", q_a, 10'h000);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_err", {ef_a, ec_a, fe_a}, 22'd0);

    mode_a = 2'b11; d_a = 10'h2A5;
    @(negedge clk);
    check("load", q_a, 10'h2A5);
    mode_a = 2'b01; ser_r_a = 1'b1;
    @(negedge clk);
    check("shift_right", q_a, 10'h352);
    mode_a = 2'b11; d_a = 10'h2A5;
    @(negedge clk);
    mode_a = 2'b10; ser_l_a = 1'b0;
    @(negedge clk);
    check("shift_left", q_a, 10'h14A);
    mode_a = 2'b00;
    repeat (5) @(negedge clk);
    check("hold", q_a, 10'h14A);

    for (int i = 0; i < 200; i++) begin
      mode_a  = 2'($urandom_range(0, 3));
      d_a     = 10'($urandom);
      ser_r_a = 1'($urandom);
      ser_l_a = 1'($urandom);
      @(negedge clk);
    end
    mode_a = 2'b00;

    sweep_a(1'b1, bn, dn);
    check("sweep1_busy_len", bn, 1024);
    check("sweep1_done_pulses", dn, 1);
    check("sweep1_q_end", q_a, 10'h3FF);
    check("sweep1_err_count", ec_a, 11'd0);

    fault2 = 1'b1;
    sweep_a(1'b1, bn, dn);
    check("sweep2_busy_len", bn, 1024);
    check("sweep2_err_count", ec_a, CHK ? 11'd576 : 11'd0);
    check("sweep2_err_flag", ef_a, CHK);
    check("sweep2_first_err", fe_a, 10'h000);
    fault2 = 1'b0;

    // abort a sweep with reset at pattern 0x100
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 400 && q_a != 10'h100; i++) @(negedge clk);
    check("abort_reached_100", q_a, 10'h100);
    rst_a = 1'b0;
    #1;
    check("abort_q", q_a, 10'h000);
    check("abort_busy", busy_a, 1'b0);
    check("abort_err", {ef_a, ec_a, fe_a}, 22'd0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_idle_q", q_a, 10'h000);

    for (int i = 0; i < 5000 && !b_fin; i++) @(negedge clk);
    check("b_finished", b_fin, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // instance B: full sweep, 3-cycle hold, p1y stuck at 0
  initial begin
    int bn, dn;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    check("b_rst_q", q_b, 10'h000);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_start_q", q_b, 10'h000);
    bn = 0; dn = 0;
    for (int i = 0; i < 3200; i++) begin
      if (busy_b) bn++;
      if (done_b) dn++;
      if (i == 5) check("b_hold_q0", q_b, 10'h001);
      mode_b = busy_b ? 2'($urandom_range(0, 3)) : 2'b00;
      d_b    = 10'($urandom);
      @(negedge clk);
    end
    check("b_busy_len", bn, 3072);
    check("b_done_pulses", dn, 1);
    check("b_q_end", q_b, 10'h3FF);
    check("b_err_count", ec_b, CHK ? 11'd240 : 11'd0);
    check("b_first_err", fe_b, CHK ? 10'h007 : 10'h000);
    check("b_err_flag", ef_b, CHK);
    b_fin = 1'b1;
  end

endmodule
